// File: rtl/vcve2_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : vcve2_pkg                                              |
// | Description : Shared vector-unit type definitions (LMUL encoding).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package vcve2_pkg;

  // Encoding follows the RVV vtype.vlmul field.
  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;

endpackage

`default_nettype wire

// File: rtl/vrf_seq_if.sv
// +----------------------------------------------------------------------+
// | Module      : vrf_seq_if                                             |
// | Description : Command / operand-stream bundle of the VRF sequencer.  |
// |               'slave' is the sequencer side, 'master' the issuing    |
// |               and lane side.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

interface vrf_seq_if #(
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5,
  parameter int VLW       = 6
) ();

  // Command channel
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            num_operands_i;
  logic                  we_i;
  logic [AddrWidth-1:0]  raddr_a_i;
  logic [AddrWidth-1:0]  raddr_b_i;
  logic [AddrWidth-1:0]  raddr_c_i;
  logic [AddrWidth-1:0]  waddr_i;
  vcve2_pkg::vlmul_e     lmul_i;
  logic [VLW-1:0]        vl_i;

  // Operand / result stream
  logic                  op_valid_o;
  logic                  op_ready_i;
  logic [ELEN-1:0]       rdata_a_o;
  logic [ELEN-1:0]       rdata_b_o;
  logic [ELEN-1:0]       rdata_c_o;
  logic [VLW-1:0]        elem_idx_o;
  logic [ELEN-1:0]       wdata_i;
  logic                  done_o;

  modport slave (
    input  req_valid_i, num_operands_i, we_i, raddr_a_i, raddr_b_i, raddr_c_i,
           waddr_i, lmul_i, vl_i, op_ready_i, wdata_i,
    output req_ready_o, op_valid_o, rdata_a_o, rdata_b_o, rdata_c_o,
           elem_idx_o, done_o
  );

  modport master (
    output req_valid_i, num_operands_i, we_i, raddr_a_i, raddr_b_i, raddr_c_i,
           waddr_i, lmul_i, vl_i, op_ready_i, wdata_i,
    input  req_ready_o, op_valid_o, rdata_a_o, rdata_b_o, rdata_c_o,
           elem_idx_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/vrf_seq.sv
// +----------------------------------------------------------------------+
// | Module      : vrf_seq                                                |
// | Description : Vector register file sequencer. Walks an LMUL group,   |
// |               reads sources and old destination from a single-port   |
// |               RAM, streams vl-bounded elements to the lane with      |
// |               backpressure and writes results tail-undisturbed.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module vrf_seq #(
  parameter int VLEN      = 128,
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  vrf_seq_if.slave  bus
);

  localparam int EPR   = VLEN / ELEN;
  localparam int VLW   = $clog2(8 * EPR) + 1;
  localparam int DEPTH = 2 ** AddrWidth;
  localparam int IW    = $clog2(VLEN);

  typedef enum logic [2:0] {
    S_IDLE, S_RA, S_RB, S_RC, S_RD, S_CAP, S_STREAM, S_WRITE
  } state_e;

  // Buffer tags carried alongside an outstanding RAM read
  localparam logic [1:0] TAG_A = 2'd0;
  localparam logic [1:0] TAG_B = 2'd1;
  localparam logic [1:0] TAG_C = 2'd2;
  localparam logic [1:0] TAG_D = 2'd3;

  state_e                state_q;
  logic [1:0]            nops_q;
  logic                  we_q;
  logic [AddrWidth-1:0]  ra_q, rb_q, rc_q, wa_q;
  logic [3:0]            nregs_q, reg_q;
  logic [VLW-1:0]        epr_eff_q, rem_q, n_q, j_q, elem_idx_q;
  logic                  op_valid_q, done_q, req_ready_q;
  logic [VLEN-1:0]       buf_a_q, buf_b_q, buf_c_q, buf_d_q;
  logic                  ld_valid_q;
  logic [1:0]            ld_tag_q;

  logic [VLEN-1:0]       mem_q [DEPTH];
  logic [VLEN-1:0]       ram_rdata_q;

  logic [3:0]            nregs_d;
  int                    shift_d;
  logic [VLW-1:0]        epr_eff_d, vlmax_d, vl_eff_d;
  logic                  ram_re, ram_we;
  logic [AddrWidth-1:0]  ram_addr, reg_off;
  logic [1:0]            tag_d;
  logic [IW-1:0]         slot_lsb;
  logic                  fire;

  // First enabled state at or after read stage 'from' (0=A,1=B,2=C,3=old dest)
  function automatic state_e first_read(input logic [1:0] nops, input logic we,
                                        input logic [2:0] from);
    if (from == 3'd0 && nops >= 2'd1) return S_RA;
    if (from <= 3'd1 && nops >= 2'd2) return S_RB;
    if (from <= 3'd2 && nops == 2'd3) return S_RC;
    if (from <= 3'd3 && we)           return S_RD;
    return S_CAP;
  endfunction

  assign fire     = op_valid_q & bus.op_ready_i;
  assign reg_off  = AddrWidth'(reg_q);
  // Element j of a register sits at the top of the vector, first-in first-out
  assign slot_lsb = IW'((EPR - 1 - int'(j_q)) * ELEN);

  // Group geometry and clamped element count for the command being offered
  always_comb begin
    nregs_d = 4'd1;
    shift_d = 0;
    case (bus.lmul_i)
      vcve2_pkg::LMUL_2:  nregs_d = 4'd2;
      vcve2_pkg::LMUL_4:  nregs_d = 4'd4;
      vcve2_pkg::LMUL_8:  nregs_d = 4'd8;
      vcve2_pkg::LMUL_F2: shift_d = 1;
      vcve2_pkg::LMUL_F4: shift_d = 2;
      vcve2_pkg::LMUL_F8: shift_d = 3;
      default:            ;
    endcase
    epr_eff_d = VLW'(((EPR >> shift_d) == 0) ? 1 : (EPR >> shift_d));
    vlmax_d   = VLW'(int'(epr_eff_d) * int'(nregs_d));
    vl_eff_d  = (bus.vl_i > vlmax_d) ? vlmax_d : bus.vl_i;
  end

  // RAM port arbitration: one read per read state, one write in S_WRITE
  always_comb begin
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    tag_d    = TAG_A;
    case (state_q)
      S_RA:    begin ram_re = 1'b1; ram_addr = ra_q + reg_off; tag_d = TAG_A; end
      S_RB:    begin ram_re = 1'b1; ram_addr = rb_q + reg_off; tag_d = TAG_B; end
      S_RC:    begin ram_re = 1'b1; ram_addr = rc_q + reg_off; tag_d = TAG_C; end
      S_RD:    begin ram_re = 1'b1; ram_addr = wa_q + reg_off; tag_d = TAG_D; end
      S_WRITE: begin ram_we = we_q; ram_addr = wa_q + reg_off; end
      default: ;
    endcase
  end

  // Single-port register RAM with one-cycle read latency; not reset
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem_q[ram_addr] <= buf_d_q;
    end else if (ram_re) begin
      ram_rdata_q <= mem_q[ram_addr];
    end
  end

  // Sequencer FSM, operand buffers and registered handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      nops_q      <= '0;
      we_q        <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      wa_q        <= '0;
      nregs_q     <= '0;
      reg_q       <= '0;
      epr_eff_q   <= '0;
      rem_q       <= '0;
      n_q         <= '0;
      j_q         <= '0;
      elem_idx_q  <= '0;
      op_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
      buf_a_q     <= '0;
      buf_b_q     <= '0;
      buf_c_q     <= '0;
      buf_d_q     <= '0;
      ld_valid_q  <= 1'b0;
      ld_tag_q    <= '0;
    end else begin
      ld_valid_q <= ram_re;
      ld_tag_q   <= tag_d;
      if (ld_valid_q) begin
        case (ld_tag_q)
          TAG_A:   buf_a_q <= ram_rdata_q;
          TAG_B:   buf_b_q <= ram_rdata_q;
          TAG_C:   buf_c_q <= ram_rdata_q;
          default: buf_d_q <= ram_rdata_q;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            nops_q      <= bus.num_operands_i;
            ra_q        <= bus.raddr_a_i;
            rb_q        <= bus.raddr_b_i;
            rc_q        <= bus.raddr_c_i;
            wa_q        <= bus.waddr_i;
            nregs_q     <= nregs_d;
            epr_eff_q   <= epr_eff_d;
            rem_q       <= vl_eff_d;
            reg_q       <= '0;
            j_q         <= '0;
            elem_idx_q  <= '0;
            req_ready_q <= 1'b0;
            if (vl_eff_d == '0) begin
              // Empty command: straight to a final S_WRITE with the write masked
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              we_q    <= bus.we_i;
              state_q <= first_read(bus.num_operands_i, bus.we_i, 3'd0);
            end
          end
        end
        S_RA:   state_q <= first_read(nops_q, we_q, 3'd1);
        S_RB:   state_q <= first_read(nops_q, we_q, 3'd2);
        S_RC:   state_q <= first_read(nops_q, we_q, 3'd3);
        S_RD:   state_q <= S_CAP;
        S_CAP: begin
          n_q        <= (rem_q < epr_eff_q) ? rem_q : epr_eff_q;
          op_valid_q <= 1'b1;
          state_q    <= S_STREAM;
        end
        S_STREAM: begin
          if (fire) begin
            buf_a_q    <= buf_a_q << ELEN;
            buf_b_q    <= buf_b_q << ELEN;
            buf_c_q    <= buf_c_q << ELEN;
            if (we_q) begin
              buf_d_q[slot_lsb +: ELEN] <= bus.wdata_i;
            end
            elem_idx_q <= elem_idx_q + VLW'(1);
            rem_q      <= rem_q - VLW'(1);
            j_q        <= j_q + VLW'(1);
            if (j_q == n_q - VLW'(1)) begin
              op_valid_q <= 1'b0;
              done_q     <= (rem_q == VLW'(1)) || (reg_q + 4'd1 >= nregs_q);
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          done_q <= 1'b0;
          if (done_q) begin
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            reg_q   <= reg_q + 4'd1;
            j_q     <= '0;
            state_q <= first_read(nops_q, we_q, 3'd0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.op_valid_o  = op_valid_q;
  assign bus.rdata_a_o   = buf_a_q[VLEN-1 -: ELEN];
  assign bus.rdata_b_o   = buf_b_q[VLEN-1 -: ELEN];
  assign bus.rdata_c_o   = buf_c_q[VLEN-1 -: ELEN];
  assign bus.elem_idx_o  = elem_idx_q;
  assign bus.done_o      = done_q;

endmodule

`default_nettype wire

// File: doc/vrf_seq.md
# vrf_seq

Parametrised vector register file sequencer for the vcve2 vector unit. It accepts one vector command at a time. For each register of the LMUL group it reads up to three source registers and the old destination register from a single-port VLEN-wide RAM, streams ELEN-wide operand elements to the execution lane over a valid/ready handshake, and collects per-element results. It writes the destination register back with tail-undisturbed semantics. It adds three things to the earlier fixed-count VRF wrapper: vl-bounded element counts, backpressure, and correct multi-register group iteration.

## Interface
- VLEN, 128: vector register width in bits; must be a multiple of ELEN.
- ELEN, 32: element/datapath width in bits.
- AddrWidth, 5: RAM address width; RAM depth is 2**AddrWidth.
- Derived: EPR = VLEN/ELEN; VLW = $clog2(8*EPR)+1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  high only in IDLE.
- num_operands_i  in  2  number of sources, 0..3 (A, B, C).
- we_i  in  1  destination write enable.
- raddr_a_i, raddr_b_i, raddr_c_i  in  AddrWidth each  base source registers.
- waddr_i  in  AddrWidth  base destination register.
- lmul_i  in  vcve2_pkg::vlmul_e  group multiplier.
- vl_i  in  VLW  requested element count.
- op_valid_o  out  1  operand element valid.
- op_ready_i  in  1  lane accepts the element; fire = op_valid_o & op_ready_i.
- rdata_a_o, rdata_b_o, rdata_c_o  out  ELEN each  top ELEN bits of the A/B/C buffers.
- elem_idx_o  out  VLW  global element index within the group.
- wdata_i  in  ELEN  result for the current element; sampled on fire when we.
- done_o  out  1  one-cycle pulse when the command completes.

## Operation
- Command fields are latched on req_valid_i & req_ready_o. Inputs are ignored afterwards.
- Group geometry:
  - nregs = 1/2/4/8 for LMUL 1/2/4/8.
  - Fractional LMUL uses nregs = 1.
  - epr_eff = EPR, or max(EPR>>k, 1) for F2/F4/F8 (k = 1/2/3).
  - VLMAX = epr_eff*nregs. Effective vl = min(vl_i, VLMAX).
- Per register r (offset r added to each base address, modulo 2**AddrWidth), the states are S_RA -> S_RB -> S_RC -> S_RD -> S_CAP -> S_STREAM -> S_WRITE.
  - S_RA/S_RB/S_RC are visited only if num_operands_i >= 1/2/3.
  - S_RD (old destination read) is visited only if we.
  - Each visited read state issues one RAM read.
  - RAM read latency is 1 cycle. Returned data loads the tagged buffer (A, B, C or RD) in the following cycle.
  - S_CAP captures the last read.
- S_STREAM:
  - n = min(epr_eff, remaining) elements, where remaining = effective vl minus elements already fired.
  - op_valid_o is high until n fires.
  - On each fire:
    - the A/B/C buffers shift left by ELEN, zero-filled;
    - if we, wdata_i is written into the RD slot at bits [VLEN-1-j*ELEN -: ELEN], where j is the element position within the register;
    - elem_idx_o increments.
- S_WRITE:
  - If we, issues a RAM write of the RD buffer to waddr+r. Tail slots j >= n keep the old destination contents.
  - If remaining > 0 and r+1 < nregs: go to S_RA for r+1.
  - Otherwise pulse done_o and return to IDLE.
- Effective vl = 0: no reads, no writes, no op_valid_o. The path is IDLE -> S_WRITE with done_o pulsed and no write issued.
- op_ready_i low stalls S_STREAM indefinitely. Buffers, index and outputs hold.
- There is no abort. rst_ni mid-command returns the block to IDLE. Buffers clear and the RAM contents are unaffected.

## Timing
- Reset values:
  - req_ready_o = 1, op_valid_o = 0, done_o = 0.
  - rdata_a_o, rdata_b_o, rdata_c_o = 0; elem_idx_o = 0.
  - All buffers and counters are 0.
- With accept in cycle 0 and R reads for the register (R = num_operands + we):
  - reads are issued in cycles 1..R;
  - the capture happens in cycle R+1;
  - op_valid_o first rises in cycle R+2.
- With no stalls, S_STREAM lasts n cycles, then 1 cycle of S_WRITE.
- The next register restarts at S_RA the cycle after S_WRITE.
- done_o is coincident with the final S_WRITE cycle. req_ready_o rises the next cycle.
- At most one RAM access per cycle.

## Test plan
- Reset mid-stream (num_operands=3, we=1):
  - response: outputs return to their reset values next edge;
  - response: a new command is accepted afterwards;
  - response: RAM is unchanged except by writes already completed.
- LMUL=1, vl=4, num_operands=2, we=1, v1=v2=all 1s, lane returns A+B:
  - response: 4 fires, elem_idx 0..3;
  - response: v3 written once with 2 per element;
  - response: done_o in cycle 9 after accept.
- LMUL=2, vl=6, num_operands=1, we=1, waddr=v4 with old v5 = 0xAAAA_AAAA per element:
  - response: v4 fully written;
  - response: v5 elements 0,1 written, elements 2,3 remain 0xAAAA_AAAA;
  - response: a single done_o pulse.
- vl_i=20 with LMUL=4 (VLMAX 16):
  - response: exactly 16 fires;
  - response: 4 register writes.
- LMUL=F8, vl=8:
  - response: epr_eff=1, one fire, one write.
- vl=0:
  - response: done_o 1 cycle after the IDLE-exit cycle;
  - response: no op_valid_o, no RAM access.
- op_ready_i toggled pseudo-randomly:
  - response: the element sequence and RAM contents are identical to the no-stall run;
  - response: rdata outputs stable while stalled.
